// File: rtl/keypad_matrix_emu.sv
// Keypad matrix emulator: answers scanner column strobes with row pulls for one
// commanded key, with LFSR-driven contact bounce around a stable hold window.
//   state   | meaning
//   IDLE    | waiting for a command, contact open
//   BNC_IN  | press bounce, contact follows LFSR bit 0
//   HOLD    | contact solidly closed for hold_q cycles
//   BNC_OUT | release bounce, contact follows LFSR bit 0
module keypad_matrix_emu #(
  parameter int          BOUNCE_CYCLES = 8,
  parameter int          HOLD_W        = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [2:0]        key_col,
  output logic [3:0]        key_row,
  output logic              busy,
  output logic              contact,
  output logic              cmd_err
);

  localparam int BW = $clog2(BOUNCE_CYCLES + 1);
  localparam int CW = (HOLD_W > BW) ? HOLD_W : BW;
  localparam logic [CW-1:0] BOUNCE_LEN = CW'(BOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, BNC_IN, HOLD, BNC_OUT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        key_q, key_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              contact_q, contact_d;
  logic              err_q, err_d;
  logic [3:0]        row_sel;
  logic [2:0]        col_sel;
  logic              col_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      hold_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      contact_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      lfsr_q    <= lfsr_d;
      contact_q <= contact_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    hold_d    = hold_q;
    lfsr_d    = lfsr_q;
    err_d     = 1'b0;
    contact_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          key_d  = cmd_key;
          hold_d = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
          if (cmd_key > 4'd11) begin
            err_d = 1'b1;
          end else begin
            state_d = BNC_IN;
            cnt_d   = BOUNCE_LEN;
          end
        end
      end
      BNC_IN: begin
        if (cnt_q == CW'(1)) begin
          state_d = HOLD;
          cnt_d   = CW'(hold_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(1)) begin
          state_d = BNC_OUT;
          cnt_d   = BOUNCE_LEN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BNC_OUT: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Taps 8,6,5,4; contact tracks bit 0 of the value held during each bounce cycle
    if (state_d == BNC_IN || state_d == BNC_OUT) begin
      lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      contact_d = lfsr_d[0];
    end else if (state_d == HOLD) begin
      contact_d = 1'b1;
    end
  end

  always_comb begin
    row_sel = '0;
    col_sel = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (key_q == 4'(r * 3 + c)) begin
          row_sel[r] = 1'b1;
          col_sel[c] = 1'b1;
        end
      end
    end
  end

  assign col_hit   = |(col_sel & ~key_col);
  assign key_row   = ~(row_sel & {4{contact_q & col_hit}});
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign contact   = contact_q;
  assign cmd_err   = err_q;

endmodule
